output_port_buffer: RTL and testbench

- Destination flit buffer at each router output port; it is the write target of the per-output round-robin arbiter.
- Accepts flits from the crossbar when the arbiter asserts write_request, and back-pressures the arbiter through destination_full.
- Tags each packet's last flit and forwards flits to the downstream link over a valid/ready handshake.
- Optional store-and-forward mode releases a packet only once all of its flits are buffered.

---
 rtl/output_port_buffer.sv | 112 +++++++++++
 tb/tb_output_port_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/output_port_buffer.sv
// Output-port flit FIFO written by the round-robin arbiter, forwarding to the downstream link.
// Tags packet tails and optionally holds flits back until the whole packet is buffered.
module output_port_buffer #(
  parameter int unsigned packet_size   = 32,
  parameter int unsigned flit_size     = 4,
  parameter int unsigned fifo_depth    = 16,
  parameter bit          store_forward = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_request,
  input  logic [flit_size-1:0] flit_in,
  output logic                 destination_full,
  output logic [flit_size-1:0] flit_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 tail_out,
  output logic                 overflow_error
);

  localparam int unsigned flit_number = packet_size / flit_size;
  localparam int unsigned ptr_w       = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned cnt_w       = $clog2(fifo_depth + 1);
  localparam int unsigned fcnt_w      = (flit_number > 1) ? $clog2(flit_number) : 1;
  localparam int unsigned pkt_w       = $clog2(fifo_depth / flit_number + 1);

  localparam logic [cnt_w-1:0]  full_count = cnt_w'(fifo_depth);
  localparam logic [fcnt_w-1:0] last_flit  = fcnt_w'(flit_number - 1);

  typedef enum logic [0:0] {StWaitPkt, StStream} out_state_e;

  logic [flit_size:0]  mem_q [fifo_depth];
  logic [ptr_w-1:0]    wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]    count_q, count_d;
  logic [fcnt_w-1:0]   in_flit_cnt_q;
  logic [pkt_w-1:0]    complete_packets_q, complete_packets_d;
  logic                overflow_q;
  out_state_e          state_q, state_d;

  logic                write_en, pop, tail_in, head_tail, sf_valid;
  logic [flit_size:0]  head;

  assign destination_full = (count_q == full_count);
  assign write_en         = write_request && !destination_full;
  assign tail_in          = (in_flit_cnt_q == last_flit);
  assign head             = mem_q[rd_ptr_q];
  assign head_tail        = head[flit_size];

  // Store-and-forward only exposes the head once a complete packet sits in the buffer.
  assign sf_valid  = (state_q == StStream) && (count_q != '0);
  assign out_valid = store_forward ? sf_valid : (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign flit_out       = out_valid ? head[flit_size-1:0] : '0;
  assign tail_out       = out_valid ? head_tail : 1'b0;
  assign overflow_error = overflow_q;

  always_comb begin
    count_d = count_q;
    unique case ({write_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    complete_packets_d = complete_packets_q;
    unique case ({write_en && tail_in, pop && head_tail})
      2'b10:   complete_packets_d = complete_packets_q + 1'b1;
      2'b01:   complete_packets_d = complete_packets_q - 1'b1;
      default: complete_packets_d = complete_packets_q;
    endcase
  end

  // Decisions use the post-update packet count so release lands one cycle after the tail write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitPkt: if (complete_packets_d != '0) state_d = StStream;
      StStream:  if (pop && head_tail && (complete_packets_d == '0)) state_d = StWaitPkt;
      default:   state_d = StWaitPkt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (write_en) mem_q[wr_ptr_q] <= {tail_in, flit_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      in_flit_cnt_q      <= '0;
      complete_packets_q <= '0;
      overflow_q         <= 1'b0;
      state_q            <= StWaitPkt;
    end else begin
      count_q            <= count_d;
      complete_packets_q <= complete_packets_d;
      state_q            <= state_d;
      if (write_en) begin
        wr_ptr_q      <= wr_ptr_q + 1'b1;
        in_flit_cnt_q <= tail_in ? '0 : in_flit_cnt_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (write_request && destination_full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_port_buffer.sv
// Drives a cut-through and a store-and-forward instance with shared stimulus and
// checks both against packet-level queue models every cycle.
module tb_output_port_buffer;

  logic       clk = 1'b0;
  logic       reset, write_request, out_ready;
  logic [3:0] flit_in;

  logic       ct_full, ct_valid, ct_tail, ct_ovf;
  logic [3:0] ct_flit;
  logic       sf_full, sf_valid, sf_tail, sf_ovf;
  logic [3:0] sf_flit;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state per instance: 0 = cut-through, 1 = store-and-forward.
  logic [4:0] mq [2][$];
  int         in_cnt [2];
  logic       ovf [2];

  always #5 clk = ~clk;

  output_port_buffer #(.store_forward(1'b0)) u_ct (
    .clk(clk), .reset(reset), .write_request(write_request), .flit_in(flit_in),
    .destination_full(ct_full), .flit_out(ct_flit), .out_valid(ct_valid),
    .out_ready(out_ready), .tail_out(ct_tail), .overflow_error(ct_ovf)
  );

  output_port_buffer #(.store_forward(1'b1)) u_sf (
    .clk(clk), .reset(reset), .write_request(write_request), .flit_in(flit_in),
    .destination_full(sf_full), .flit_out(sf_flit), .out_valid(sf_valid),
    .out_ready(out_ready), .tail_out(sf_tail), .overflow_error(sf_ovf)
  );

  function automatic bit has_tail(int m);
    for (int i = 0; i < mq[m].size(); i++) if (mq[m][i][4]) return 1'b1;
    return 1'b0;
  endfunction

  // Cut-through shows any stored flit; store-and-forward only when a full packet is present.
  function automatic bit exp_valid(int m);
    return (m == 0) ? (mq[m].size() != 0) : has_tail(m);
  endfunction

  task automatic check(input int m, input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL dut%0d %s observed=%h expected=%h", m, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic       v;
      logic [3:0] f;
      logic       t;
      v = exp_valid(m);
      f = v ? mq[m][0][3:0] : 4'h0;
      t = v ? mq[m][0][4] : 1'b0;
      check(m, "out_valid", {3'b0, (m == 0) ? ct_valid : sf_valid}, {3'b0, v});
      check(m, "flit_out", (m == 0) ? ct_flit : sf_flit, f);
      check(m, "tail_out", {3'b0, (m == 0) ? ct_tail : sf_tail}, {3'b0, t});
      check(m, "dest_full", {3'b0, (m == 0) ? ct_full : sf_full},
            {3'b0, mq[m].size() == 16});
      check(m, "overflow", {3'b0, (m == 0) ? ct_ovf : sf_ovf}, {3'b0, ovf[m]});
    end
  endtask

  task automatic clear_models();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      in_cnt[m] = 0;
      ovf[m] = 1'b0;
    end
  endtask

  task automatic cycle(input logic wr, input logic [3:0] d, input logic rdy);
    bit v [2];
    bit full [2];
    check_all();
    write_request = wr;
    flit_in       = d;
    out_ready     = rdy;
    for (int m = 0; m < 2; m++) begin
      v[m]    = exp_valid(m);
      full[m] = (mq[m].size() == 16);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (v[m] && rdy) mq[m].delete(0);
      if (wr && full[m]) ovf[m] = 1'b1;
      if (wr && !full[m]) begin
        mq[m].push_back({in_cnt[m] == 7, d});
        in_cnt[m] = (in_cnt[m] + 1) % 8;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    clear_models();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    write_request = 1'b0;
    out_ready = 1'b0;
    flit_in = 4'h0;
    clear_models();
    do_reset();

    // Eight flits streamed straight through.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b1);

    // Fill to 16, then one write while full, then drain.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0);
    cycle(1'b1, 4'hf, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'h0, 1'b1);

    // Full buffer: pop + write same cycle rejects the write; retry is accepted.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i + 3), 1'b0);
    cycle(1'b1, 4'ha, 1'b1);
    cycle(1'b1, 4'hb, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'h0, 1'b1);

    // Partial packet held back in store-and-forward, released after its tail.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'(i + 8), 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'h7, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'h0, 1'b1);

    // Reset mid-packet, then a fresh packet.
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 1), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(15 - i), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'h0, 1'b1);

    // Continuous writes with toggling ready, wrapping the pointers.
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'(i * 7 + 1), 1'(i % 2));
    for (int i = 0; i < 40; i++) cycle(1'b0, 4'h0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 30; i++) cycle(1'b0, 4'h0, 1'b1);

    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
